// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM word-address and word widths
//   arb_state_e             : arbiter FSM states
//   arb_port_e              : requester identifier (grant / priority pointer)
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_ACK     = 2'd3
   } arb_state_e;

   typedef enum logic {
      PORT_P0 = 1'b0,
      PORT_P1 = 1'b1
   } arb_port_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection for the two-port RAM arbiter.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : ties resolved by the priority pointer; the next pointer always
//               names the port that did not win.
//   undefined : fixed priority, p0 wins ties; no pointer ports exist.
// Ports:
//   req0_i, req1_i : pending requests
//   ptr_i          : current priority pointer (round-robin build only)
//   ptr_next_o     : pointer value to load on a grant (round-robin build only)
//   gnt_valid_o    : at least one request is pending
//   gnt_port_o     : winning port (meaningful while gnt_valid_o=1)
module mem_arb_select
   import mem_arbiter_pkg::*;
(
   input  logic      req0_i,
   input  logic      req1_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  arb_port_e ptr_i,
   output arb_port_e ptr_next_o,
`endif
   output logic      gnt_valid_o,
   output arb_port_e gnt_port_o
);

   always_comb begin
      gnt_valid_o = req0_i | req1_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (req0_i && req1_i) begin
         gnt_port_o = ptr_i;
      end else if (req1_i) begin
         gnt_port_o = PORT_P1;
      end else begin
         gnt_port_o = PORT_P0;
      end
      // The pointer moves away from the winner even when it had no rival.
      ptr_next_o = (gnt_port_o == PORT_P0) ? PORT_P1 : PORT_P0;
`else
      gnt_port_o = (req0_i || !req1_i) ? PORT_P0 : PORT_P1;
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with registered read data.
// Each transaction takes four cycles: IDLE (grant + latch), ISSUE (address and
// write strobe on the RAM), CAPTURE (RAM read data registered into the
// winner's rdata), ACK (one-cycle completion pulse to the winner).
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie-break when
// defined, fixed p0 priority when undefined).
// Ports:
//   clk, clr                 : clock, synchronous active-high reset
//   pN_req/we/addr/wdata     : requester N transaction (level request)
//   pN_ack, pN_rdata         : completion pulse and read result
//   mem_write/addr/din       : registered RAM controls
//   mem_dout                 : RAM registered read data
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a request; grants and latches the winner
// ST_ISSUE   | latched address/data/write strobe presented to the RAM
// ST_CAPTURE | RAM output registered into the winner's rdata
// ST_ACK     | winner's ack high for this cycle
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   arb_state_e        state_q, state_d;
   arb_port_e         win_q, win_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;

   logic              gnt_valid;
   arb_port_e         gnt_port;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   arb_port_e         ptr_q, ptr_d;
   arb_port_e         ptr_next;
`endif

   mem_arb_select u_select (
      .req0_i      (p0_req),
      .req1_i      (p1_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .ptr_i       (ptr_q),
      .ptr_next_o  (ptr_next),
`endif
      .gnt_valid_o (gnt_valid),
      .gnt_port_o  (gnt_port)
   );

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d = ST_ISSUE;
               win_d   = gnt_port;
               // Latching straight into the RAM-facing registers makes the
               // write strobe high for the ISSUE cycle only.
               if (gnt_port == PORT_P1) begin
                  mem_write_d = p1_we;
                  mem_addr_d  = p1_addr;
                  mem_din_d   = p1_wdata;
               end else begin
                  mem_write_d = p0_we;
                  mem_addr_d  = p0_addr;
                  mem_din_d   = p0_wdata;
               end
`ifdef MEM_ARB_ROUND_ROBIN_EN
               ptr_d = ptr_next;
`endif
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = ST_ACK;
            // Writes also capture mem_dout: the RAM returns the new word.
            if (win_q == PORT_P1) begin
               rdata1_d = mem_dout;
               ack1_d   = 1'b1;
            end else begin
               rdata0_d = mem_dout;
               ack0_d   = 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         win_q       <= PORT_P0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= PORT_P0;
`endif
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign p0_ack    = ack0_q;
   assign p1_ack    = ack1_q;
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int NWORDS = 512;

   logic          clk = 1'b0;
   logic          clr;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_ack, p1_ack;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .clr      (clr),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_ack   (p0_ack),
      .p0_rdata (p0_rdata),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p1_ack   (p1_ack),
      .p1_rdata (p1_rdata),
      .mem_write(mem_write),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural RAM: registered read, write-then-read.
   logic [DW-1:0] ram [NWORDS];
   initial begin
      for (int i = 0; i < NWORDS; i++) ram[i] = init_word(i);
      mem_dout = '0;
      forever begin
         @(posedge clk);
         if (mem_write) begin
            ram[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
         end else begin
            mem_dout      <= ram[mem_addr];
         end
      end
   end

   // Inputs as seen at each rising edge.
   logic          s_clr, s_req0, s_req1, s_we0, s_we1;
   logic [AW-1:0] s_addr0, s_addr1;
   logic [DW-1:0] s_wd0, s_wd1;
   always @(posedge clk) begin
      s_clr   <= clr;
      s_req0  <= p0_req;
      s_req1  <= p1_req;
      s_we0   <= p0_we;
      s_we1   <= p1_we;
      s_addr0 <= p0_addr;
      s_addr1 <= p1_addr;
      s_wd0   <= p0_wdata;
      s_wd1   <= p1_wdata;
   end

   // Transaction-level reference: a granted transaction is 'ph' edges old
   // (1: on the RAM bus, 2: data returned, 3: acknowledged, 0: free).
   int            ph;
   bit            win;
   bit            ptr;
   bit            model_on;
   bit            just_rst;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] rd0, rd1;
   logic [DW-1:0] shadow [NWORDS];

   initial begin
      for (int i = 0; i < NWORDS; i++) shadow[i] = init_word(i);
      model_on = 1'b0;
      ph = 0; win = 1'b0; ptr = 1'b0; just_rst = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; rd0 = '0; rd1 = '0;
      forever begin
         @(negedge clk);
         if (s_clr) begin
            if (ph == 1 && m_we) shadow[m_addr] = m_wdata;
            ph = 0; ptr = 1'b0; rd0 = '0; rd1 = '0;
            model_on = 1'b1; just_rst = 1'b1;
         end else if (model_on) begin
            just_rst = 1'b0;
            case (ph)
               0: if (s_req0 || s_req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                     win = (s_req0 && s_req1) ? ptr : s_req1;
                     ptr = !win;
`else
                     win = !s_req0;
`endif
                     m_we    = win ? s_we1   : s_we0;
                     m_addr  = win ? s_addr1 : s_addr0;
                     m_wdata = win ? s_wd1   : s_wd0;
                     ph = 1;
                  end
               1: begin
                  if (m_we) shadow[m_addr] = m_wdata;
                  ph = 2;
               end
               2: begin
                  if (win) rd1 = shadow[m_addr];
                  else     rd0 = shadow[m_addr];
                  ph = 3;
               end
               default: ph = 0;
            endcase
         end
         if (model_on) begin
            chk("p0_ack",    32'(p0_ack),    32'(ph == 3 && !win));
            chk("p1_ack",    32'(p1_ack),    32'(ph == 3 && win));
            chk("p0_rdata",  p0_rdata,       rd0);
            chk("p1_rdata",  p1_rdata,       rd1);
            chk("mem_write", 32'(mem_write), 32'(ph == 1 && m_we));
            if (ph == 1) begin
               chk("mem_addr", 32'(mem_addr), 32'(m_addr));
               chk("mem_din",  mem_din,       m_wdata);
            end
            if (just_rst) begin
               chk("rst_mem_addr", 32'(mem_addr), 32'd0);
               chk("rst_mem_din",  mem_din,       32'd0);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet();
      p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
      p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
   endtask

   // One transaction from an idle arbiter; returns edges to ack (-1 on
   // timeout) and the read data, then steps into the following IDLE.
   task automatic txn(input bit port, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
      end else begin
         p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
      end
      lat = -1;
      rd  = '0;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         if (c == 1) begin
            p0_req = 1'b0;
            p1_req = 1'b0;
         end
         chk("other_ack", 32'(port ? p0_ack : p1_ack), 32'd0);
         if (port ? p1_ack : p0_ack) begin
            lat = c;
            rd  = port ? p1_rdata : p0_rdata;
            break;
         end
      end
      if (lat > 0) cyc();
   endtask

   int            lat;
   logic [DW-1:0] rd;
   int            order [4];
   int            exp_order [4];
   int            nack;

   initial begin
      quiet();
      clr = 1'b1;
      @(negedge clk);
      cyc();
      clr = 1'b0;
      chk("rst_p0_ack",    32'(p0_ack),    32'd0);
      chk("rst_p1_ack",    32'(p1_ack),    32'd0);
      chk("rst_p0_rdata",  p0_rdata,       32'd0);
      chk("rst_p1_rdata",  p1_rdata,       32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);

      // First p0-only request after reset.
      txn(1'b0, 1'b0, 9'h010, 32'd0, lat, rd);
      chk("first_lat",   32'(lat), 32'd3);
      chk("first_rdata", rd,       init_word(16));

      // p0 write 0x005 then read it back.
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h005; p0_wdata = 32'hDEAD_BEEF;
      cyc();
      chk("wr_issue_we",   32'(mem_write), 32'd1);
      chk("wr_issue_addr", 32'(mem_addr),  32'h005);
      chk("wr_issue_din",  mem_din,        32'hDEAD_BEEF);
      p0_req = 1'b0;
      cyc();
      chk("wr_capture_we", 32'(mem_write), 32'd0);
      cyc();
      chk("wr_ack",        32'(p0_ack),    32'd1);
      chk("wr_rdata",      p0_rdata,       32'hDEAD_BEEF);
      cyc();
      chk("wr_ack_pulse",  32'(p0_ack),    32'd0);
      txn(1'b0, 1'b0, 9'h005, 32'd0, lat, rd);
      chk("rd_lat",   32'(lat), 32'd3);
      chk("rd_rdata", rd,       32'hDEAD_BEEF);

      // Both requests held for four transactions from a fresh pointer.
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
      p0_addr = 9'h020; p1_addr = 9'h021;
      nack = 0;
      for (int c = 0; c < 40 && nack < 4; c++) begin
         cyc();
         if (p0_ack) begin
            order[nack] = 0;
            nack++;
         end else if (p1_ack) begin
            order[nack] = 1;
            nack++;
         end
      end
      quiet();
      repeat (5) cyc();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      chk("arb_count", 32'(nack), 32'd4);
      for (int i = 0; i < 4; i++) chk("arb_order", 32'(order[i]), 32'(exp_order[i]));

      // p1 read at the top address.
      txn(1'b1, 1'b0, 9'h1FF, 32'd0, lat, rd);
      chk("top_lat",   32'(lat), 32'd3);
      chk("top_rdata", rd,       init_word(511));

      // Reset during CAPTURE of a p0 read.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h00A;
      cyc();
      p0_req = 1'b0;
      cyc();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("abort_ack",   32'(p0_ack), 32'd0);
      chk("abort_rdata", p0_rdata,    32'd0);
      cyc();
      chk("abort_ack2",  32'(p0_ack), 32'd0);
      txn(1'b0, 1'b0, 9'h00A, 32'd0, lat, rd);
      chk("after_abort_lat",   32'(lat), 32'd3);
      chk("after_abort_rdata", rd,       init_word(10));

      // Reset in the ISSUE cycle of a write still commits the write.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h033; p1_wdata = 32'h1234_5678;
      cyc();
      p1_req = 1'b0;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_wr_ack", 32'(p1_ack), 32'd0);
      cyc();
      txn(1'b0, 1'b0, 9'h033, 32'd0, lat, rd);
      chk("clr_wr_lat",   32'(lat), 32'd3);
      chk("clr_wr_rdata", rd,       32'h1234_5678);

      // Random traffic against the reference model.
      for (int i = 0; i < 500; i++) begin
         p0_req   = 1'($urandom_range(0, 1));
         p1_req   = 1'($urandom_range(0, 1));
         p0_we    = 1'($urandom_range(0, 1));
         p1_we    = 1'($urandom_range(0, 1));
         p0_addr  = AW'($urandom_range(0, 15) | (i[0] ? 9'h1F0 : 9'h000));
         p1_addr  = AW'($urandom_range(0, 15) | (i[1] ? 9'h1F0 : 9'h000));
         p0_wdata = $urandom;
         p1_wdata = $urandom;
         clr      = ($urandom_range(0, 63) == 0);
         cyc();
      end
      clr = 1'b0;
      quiet();
      repeat (6) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, RAM word-address width (512 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports p0_req/p1_req  input  1  requester N has a pending transaction (level).
REQ-006 The block SHALL have ports p0_we/p1_we  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have ports p0_addr/p1_addr  input  ADDR_W  word address.
REQ-008 The block SHALL have ports p0_wdata/p1_wdata  input  DATA_W  write data.
REQ-009 The block SHALL have ports p0_ack/p1_ack  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have ports p0_rdata/p1_rdata  output  DATA_W  read result, valid while pN_ack=1.
REQ-011 The block SHALL have port mem_write  output  1  RAM write enable, registered.
REQ-012 The block SHALL have port mem_addr  output  ADDR_W  RAM address, registered.
REQ-013 The block SHALL have port mem_din  output  DATA_W  RAM write data, registered.
REQ-014 The block SHALL have port mem_dout  input  DATA_W  RAM registered read data, valid one cycle after address issue.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, CAPTURE, ACK; transitions IDLE->ISSUE on any req, ISSUE->CAPTURE, CAPTURE->ACK, ACK->IDLE unconditionally.
REQ-016 In IDLE with any req high, the block SHALL select a winner and latch its we/addr/wdata; requester inputs are don't-care after that edge.
REQ-017 In ISSUE, mem_addr/mem_din SHALL carry the latched values and mem_write SHALL equal latched we; mem_write SHALL be 0 in every other state.
REQ-018 In CAPTURE, the block SHALL register mem_dout into the winner's rdata register.
REQ-019 In ACK, the winner's ack SHALL be 1 for exactly one cycle and the loser's ack SHALL be 0.
REQ-020 Latency SHALL be fixed: req sampled at edge k -> ack high in cycle k+3; one transaction per 4 cycles maximum.
REQ-021 For writes, pN_rdata SHALL return mem_dout (the written word, RAM is write-then-read).
REQ-022 A req still high in the IDLE following its ACK SHALL be treated as a new transaction.
REQ-023 With both reqs high in IDLE, the winner SHALL be the port indicated by the priority pointer; the pointer SHALL then point to the other port.
REQ-024 With only one req high, that port SHALL win regardless of pointer; the pointer SHALL still move to the other port.
REQ-025 pN_rdata SHALL hold its last value until that port's next CAPTURE.

Reset
REQ-026 When clr is 1 at a rising edge, state SHALL become IDLE, pointer SHALL select p0, and all outputs and rdata registers SHALL become 0 after that edge.
REQ-027 clr during ISSUE/CAPTURE/ACK SHALL abort the transaction with no ack; a write issued in the cycle clr is sampled SHALL still commit to RAM (RAM contents are not reset).

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined: pointer behaviour per REQ-023/024.
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, p0 always wins ties; pointer logic absent.

Structure
REQ-030 A shared package SHALL hold ADDR_W/DATA_W defaults and the FSM state enum.
REQ-031 The winner-select logic SHALL be one sub-module, mem_arb_select (reqs + pointer -> grant, next pointer).

Verification
REQ-032 Reset: clr=1 one cycle -> all outputs 0, mem_write=0, next p0-only req granted first.
REQ-033 p0 write addr 0x005 data 0xDEADBEEF, then p0 read 0x005 -> mem_write=1 only in ISSUE; read ack at k+3 with p0_rdata=0xDEADBEEF.
REQ-034 Both reqs held high, 4 transactions -> ack order p0,p1,p0,p1 (macro defined); p0,p0,p0,p0 (undefined).
REQ-035 p1 read 0x1FF (wrap boundary) while p0 idle -> p1_ack at k+3, p0_ack never high, p1_rdata = RAM[0x1FF].
REQ-036 clr asserted in CAPTURE of a p0 read -> no p0_ack, state IDLE next cycle, p0_rdata=0.
